// File: rtl/oops_mem_arbiter_if.sv
// Requester channels plus the single shared physical memory port around oops_mem_arbiter.
// Handshake: ch_read/ch_write are levels held until the one-cycle ch_resp pulse; pmem_read/pmem_write stay high until the one-cycle pmem_resp.
interface oops_mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MBE_W = DATA_W / 8;

    // Requester side
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*MBE_W-1:0]  ch_mbe;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic [DATA_W-1:0]        ch_rdata;

    // Shared physical memory side
    logic                     pmem_read;
    logic                     pmem_write;
    logic [MBE_W-1:0]         pmem_mbe;
    logic [ADDR_W-1:0]        pmem_addr;
    logic [DATA_W-1:0]        pmem_wdata;
    logic                     pmem_resp;
    logic [DATA_W-1:0]        pmem_rdata;

    // The arbiter itself
    modport slave (
        input  ch_read, ch_write, ch_mbe, ch_addr, ch_wdata,
        input  pmem_resp, pmem_rdata,
        output ch_resp, ch_rdata,
        output pmem_read, pmem_write, pmem_mbe, pmem_addr, pmem_wdata
    );

    // The environment: requesting cores and the physical memory
    modport master (
        output ch_read, ch_write, ch_mbe, ch_addr, ch_wdata,
        output pmem_resp, pmem_rdata,
        input  ch_resp, ch_rdata,
        input  pmem_read, pmem_write, pmem_mbe, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/oops_mem_arbiter.sv
// N-channel arbiter onto one shared memory port: one transaction in flight, fixed-priority or
// round-robin grant, registered pmem request and a registered one-cycle response to the winner.
module oops_mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1,
    localparam int MBE_W  = DATA_W / 8,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    oops_mem_arbiter_if.slave     io_bus,
    output logic [1:0]            o_dbg_state,
    output logic [PTR_W-1:0]      o_dbg_ptr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_take;
    logic                w_finish;

    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_req_rot;
    logic [PTR_W-1:0]    w_grant;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic                w_grant_wr;

    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_gnt;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [MBE_W-1:0]    r_mbe;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [NUM_CH-1:0]   r_ch_resp;

    assign w_req = io_bus.ch_read | io_bus.ch_write;

    // Rotate so that bit k of w_req_rot is channel (r_ptr + k) mod NUM_CH.
    assign w_req_rot = NUM_CH'({w_req, w_req} >> r_ptr);

    always_comb begin : p_winner
        int idx;
        idx     = 0;
        w_grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (RR_MODE != 0) begin
                if (w_req_rot[k]) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= NUM_CH) begin
                        idx = idx - NUM_CH;
                    end
                    w_grant = PTR_W'(idx);
                end
            end else if (w_req[k]) begin
                w_grant = PTR_W'(k);
            end
        end
    end

    assign w_ptr_nxt  = (w_grant == PTR_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
    assign w_grant_wr = io_bus.ch_write[w_grant];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (io_bus.pmem_resp) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A write wins over a read when a channel raises both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_op_wr      <= 1'b0;
            r_addr       <= '0;
            r_mbe        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_ch_resp    <= '0;
        end else begin
            r_ch_resp <= '0;
            if (w_take) begin
                r_gnt        <= w_grant;
                r_ptr        <= w_ptr_nxt;
                r_op_wr      <= w_grant_wr;
                r_addr       <= io_bus.ch_addr[w_grant*ADDR_W +: ADDR_W];
                r_mbe        <= io_bus.ch_mbe[w_grant*MBE_W +: MBE_W];
                r_wdata      <= io_bus.ch_wdata[w_grant*DATA_W +: DATA_W];
                r_pmem_read  <= ~w_grant_wr;
                r_pmem_write <= w_grant_wr;
            end
            if (w_finish) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_ch_resp    <= ONE_HOT0 << r_gnt;
                if (!r_op_wr) begin
                    r_rdata <= io_bus.pmem_rdata;
                end
            end
        end
    end

    assign io_bus.pmem_read  = r_pmem_read;
    assign io_bus.pmem_write = r_pmem_write;
    assign io_bus.pmem_addr  = r_addr;
    assign io_bus.pmem_mbe   = r_mbe;
    assign io_bus.pmem_wdata = r_wdata;
    assign io_bus.ch_resp    = r_ch_resp;
    assign io_bus.ch_rdata   = r_rdata;

    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule
